// File: rtl/ch375_dev_uart_pkg.sv
// Shared definitions for the CH375 device-side UART: register map,
// status bit positions, FIFO entry layout and FSM state encodings.
package ch375_dev_uart_pkg;

    // Register word indices (software byte address = index * 4)
    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_STAT = 3'd1;
    localparam logic [2:0] REG_TX   = 3'd2;
    localparam logic [2:0] REG_NINT = 3'd3;

    // Bit positions inside the 32-bit word (byte lane d[31:24])
    localparam int STAT_NONEMPTY = 24;
    localparam int STAT_FLAG     = 25;
    localparam int STAT_OVF      = 26;
    localparam int STAT_FERR     = 27;
    localparam int STAT_TX_IDLE  = 28;
    localparam int NINT_BIT      = 24;
    localparam int CMD_POP       = 24;
    localparam int CMD_CLEAR     = 25;

    // One received frame: flag=1 marks a command byte, flag=0 a data byte
    typedef struct packed {
        logic       flag;
        logic [7:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_BIT9, TX_STOP} tx_state_t;

endpackage

// File: rtl/ch375_dev_uart_if.sv
// MMIO bus bundle between the CPU side (master) and the UART (slave).
interface ch375_dev_uart_if;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        irq;

    modport master (output a, output d, output we, input spo, input irq);
    modport slave  (input a, input d, input we, output spo, output irq);
endinterface

// File: rtl/baud_rate_gen.sv
// Bit-timing enables: rxclk_en at SAMPLE_MULTIPLIER x baud, txclk_en at baud.
// txclk_en is derived from the rx divider so both are phase locked.
module baud_rate_gen #(
    parameter int CLOCK_FREQ        = 62500000,
    parameter int BAUD_RATE         = 9600,
    parameter int SAMPLE_MULTIPLIER = 16
) (
    input  logic clk,
    input  logic rst,
    output logic rxclk_en,
    output logic txclk_en
);
    localparam int RX_DIV_RAW = CLOCK_FREQ / (BAUD_RATE * SAMPLE_MULTIPLIER);
    localparam int RX_DIV     = (RX_DIV_RAW < 1) ? 1 : RX_DIV_RAW;
    localparam int DW         = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam int TW         = (SAMPLE_MULTIPLIER > 1) ? $clog2(SAMPLE_MULTIPLIER) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [TW-1:0] tick_q, tick_d;

    // Divider and oversample tick counter next-state
    always_comb begin
        rxclk_en = (div_q == DW'(RX_DIV - 1));
        txclk_en = rxclk_en && (tick_q == TW'(SAMPLE_MULTIPLIER - 1));
        div_d    = rxclk_en ? '0 : div_q + DW'(1);
        tick_d   = tick_q;
        if (rxclk_en) begin
            tick_d = txclk_en ? '0 : tick_q + TW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= '0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end
endmodule

// File: rtl/ch375_dev_fifo.sv
// Synchronous FIFO of received frames; head entry readable with no latency.
module ch375_dev_fifo
    import ch375_dev_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fifo_entry_t                din,
    input  logic                       pop,
    output fifo_entry_t                dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_eff, push_eff;

    // Pop needs data; push into a full FIFO only works if a pop frees a slot
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        pop_eff  = pop && !empty;
        push_eff = push && (!full || pop_eff);
        wr_ptr_d = push_eff ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_eff  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_eff && !pop_eff) count_d = count_q + (AW+1)'(1);
        if (pop_eff && !push_eff) count_d = count_q - (AW+1)'(1);
        dout     = mem_q[rd_ptr_q];
        count    = count_q;
    end

    // Storage array, no reset needed on the payload
    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= din;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/ch375_dev_uart.sv
// CH375 device-side 9-bit UART endpoint: receives flagged host frames into a
// FIFO, transmits reply frames, and exposes an MMIO register window.
module ch375_dev_uart
    import ch375_dev_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 62500000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    ch375_dev_uart_if.slave  bus,
    input  logic             dev_rx,
    output logic             dev_tx,
    output logic             dev_nint
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic rxclk_en, txclk_en;

    baud_rate_gen #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE), .SAMPLE_MULTIPLIER(16)) u_baud (
        .clk(clk), .rst(rst), .rxclk_en(rxclk_en), .txclk_en(txclk_en)
    );

    rx_state_t   rx_state_q, rx_state_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic        rx_meta_q, rx_sync_q, rx_last_q, rx_last_d;
    logic [3:0]  rx_tick_q, rx_tick_d, rx_bit_q, rx_bit_d;
    logic [8:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        ovf_q, ovf_d, ferr_q, ferr_d, nint_q, nint_d, irq_q, irq_d;
    logic        rx_push, ferr_set, ovf_set, accept, pop_req, clr_req;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fifo_entry_t fifo_head;
    logic [31:0] spo_c;
    logic        unused_d;

    assign unused_d = ^bus.d[23:0];

    ch375_dev_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst),
        .push(accept), .din('{flag: rx_shift_q[8], data: rx_shift_q[7:0]}),
        .pop(pop_req), .dout(fifo_head),
        .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );

    // RX FSM, bus commands, sticky errors and TX FSM next-state
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_last_d  = rx_last_q;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        if (rxclk_en) begin
            rx_last_d = rx_sync_q;
            case (rx_state_q)
                RX_START: begin
                    // Only a high-to-low transition starts a frame, so a
                    // line held low after a framing error cannot re-trigger.
                    if (rx_tick_q != 4'd0 || (!rx_sync_q && rx_last_q)) begin
                        rx_tick_d = rx_tick_q + 4'd1;
                        if (rx_tick_q == 4'd15) begin
                            rx_state_d = RX_DATA;
                            rx_bit_d   = 4'd0;
                        end
                    end
                end
                RX_DATA: begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd8) rx_shift_d = {rx_sync_q, rx_shift_q[8:1]};
                    if (rx_tick_q == 4'd15) begin
                        rx_bit_d = rx_bit_q + 4'd1;
                        if (rx_bit_q == 4'd8) rx_state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd8) begin
                        rx_push    = rx_sync_q;
                        ferr_set   = !rx_sync_q;
                        rx_state_d = RX_START;
                        rx_tick_d  = 4'd0;
                    end
                end
                default: rx_state_d = RX_START;
            endcase
        end

        pop_req = bus.we && (bus.a == REG_STAT) && bus.d[CMD_POP];
        clr_req = bus.we && (bus.a == REG_STAT) && bus.d[CMD_CLEAR];
        // A full FIFO still accepts when a pop frees a slot this cycle
        ovf_set = rx_push && fifo_full && !pop_req;
        accept  = rx_push && !ovf_set;
        irq_d   = accept;
        ovf_d   = ovf_set  ? 1'b1 : (clr_req ? 1'b0 : ovf_q);
        ferr_d  = ferr_set ? 1'b1 : (clr_req ? 1'b0 : ferr_q);
        nint_d  = (bus.we && bus.a == REG_NINT) ? bus.d[NINT_BIT] : nint_q;

        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_idx_d   = tx_idx_q;
        case (tx_state_q)
            TX_IDLE: if (bus.we && bus.a == REG_TX) begin
                tx_data_d  = bus.d[31:24];
                tx_state_d = TX_START;
            end
            TX_START: if (txclk_en) begin
                tx_state_d = TX_DATA;
                tx_idx_d   = 3'd0;
            end
            TX_DATA: if (txclk_en) begin
                if (tx_idx_q == 3'd7) tx_state_d = TX_BIT9;
                else                  tx_idx_d   = tx_idx_q + 3'd1;
            end
            TX_BIT9: if (txclk_en) tx_state_d = TX_STOP;
            TX_STOP: if (txclk_en) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Line driver and register read mux, both purely from current state
    always_comb begin
        case (tx_state_q)
            TX_START: dev_tx = 1'b0;
            TX_DATA:  dev_tx = tx_data_q[tx_idx_q];
            TX_BIT9:  dev_tx = 1'b0;
            default:  dev_tx = 1'b1;
        endcase
        spo_c = '0;
        case (bus.a)
            REG_DATA: if (!fifo_empty) spo_c[31:24] = fifo_head.data;
            REG_STAT: begin
                spo_c[STAT_NONEMPTY] = (fifo_count != '0);
                spo_c[STAT_FLAG]     = fifo_head.flag && !fifo_empty;
                spo_c[STAT_OVF]      = ovf_q;
                spo_c[STAT_FERR]     = ferr_q;
                spo_c[STAT_TX_IDLE]  = (tx_state_q == TX_IDLE);
            end
            REG_NINT: spo_c[NINT_BIT] = nint_q;
            default: spo_c = '0;
        endcase
        bus.spo  = spo_c;
        bus.irq  = irq_q;
        dev_nint = nint_q;
    end

    // State registers; reset aborts any frame in progress on either side
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_START;
            tx_state_q <= TX_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_last_q  <= 1'b1;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            tx_data_q  <= '0;
            tx_idx_q   <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            nint_q     <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            rx_meta_q  <= dev_rx;
            rx_sync_q  <= rx_meta_q;
            rx_last_q  <= rx_last_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            tx_data_q  <= tx_data_d;
            tx_idx_q   <= tx_idx_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            nint_q     <= nint_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_ch375_dev_uart.sv
// Randomized self-checking bench for ch375_dev_uart with a queue-based model.
module tb_ch375_dev_uart;
    localparam int BIT   = 32;   // clocks per bit: 3200 Hz / 100 baud
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_rx = 1'b1;
    logic loop_en = 1'b0;
    logic dev_tx, dev_nint;
    wire  dev_rx = loop_en ? dev_tx : host_rx;

    ch375_dev_uart_if bus();

    ch375_dev_uart #(.CLOCK_FREQ(3200), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .dev_rx(dev_rx), .dev_tx(dev_tx), .dev_nint(dev_nint)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int irq_cnt = 0;
    int cyc     = 0;
    int tx_phase = 0;

    // Reference model: received-frame queue and sticky flags
    logic [8:0] mq[$];
    bit m_ovf  = 1'b0;
    bit m_ferr = 1'b0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (bus.irq === 1'b1) irq_cnt++;

    function automatic logic [31:0] exp_stat(input bit tx_idle);
        logic [31:0] s = '0;
        s[24] = (mq.size() > 0);
        s[25] = (mq.size() > 0) ? mq[0][8] : 1'b0;
        s[26] = m_ovf;
        s[27] = m_ferr;
        s[28] = tx_idle;
        return s;
    endfunction

    function automatic logic [31:0] exp_data();
        logic [31:0] v = '0;
        if (mq.size() > 0) v[31:24] = mq[0][7:0];
        return v;
    endfunction

    task automatic reg_write(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.a = a; bus.d = v; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0; bus.d = '0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.a = a;
        #1 v = bus.spo;
    endtask

    // Drive one host frame and update the model; exp_irq tells whether it is queued
    task automatic send_frame(input logic [7:0] data, input logic flag,
                              input logic stop_ok, output int exp_irq);
        logic [10:0] bits;
        bits = {stop_ok, flag, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            host_rx = bits[i];
            repeat (BIT) @(negedge clk);
        end
        host_rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        exp_irq = 0;
        if (!stop_ok) m_ferr = 1'b1;
        else if (mq.size() < DEPTH) begin
            mq.push_back({flag, data});
            exp_irq = 1;
        end else m_ovf = 1'b1;
    endtask

    task automatic do_pop();
        reg_write(3'd1, 32'h0100_0000);
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (dev_tx !== 1'b1 || dev_nint !== 1'b1 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_lines: tx=%b nint=%b irq=%b, want 1 1 0", dev_tx, dev_nint, bus.irq);
        end
        reg_read(3'd1, v);
        vectors++;
        if (v !== 32'h1000_0000) begin errors++; $display("FAIL reset_stat: got %h want 10000000", v); end
        reg_read(3'd0, v);
        vectors++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", v); end
        $display("test_reset done");
    endtask

    task automatic test_cmd_frame();
        logic [31:0] v;
        int c0, ei;
        c0 = irq_cnt;
        send_frame(8'h15, 1'b1, 1'b1, ei);
        vectors++;
        if (irq_cnt - c0 !== ei) begin errors++; $display("FAIL cmd_irq: got %0d pulses want %0d", irq_cnt - c0, ei); end
        reg_read(3'd1, v);
        vectors++;
        if (v !== exp_stat(1)) begin errors++; $display("FAIL cmd_stat: got %h want %h", v, exp_stat(1)); end
        reg_read(3'd0, v);
        vectors++;
        if (v !== exp_data()) begin errors++; $display("FAIL cmd_data: got %h want %h", v, exp_data()); end
        do_pop();
        reg_read(3'd1, v);
        vectors++;
        if (v !== exp_stat(1)) begin errors++; $display("FAIL cmd_pop_stat: got %h want %h", v, exp_stat(1)); end
        $display("test_cmd_frame: sent 15 flag 1, stat now %h", v);
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        int c0, ei, tot;
        c0 = irq_cnt; tot = 0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, ei);
            tot += ei;
        end
        vectors++;
        if (irq_cnt - c0 !== tot) begin errors++; $display("FAIL ovf_irq: got %0d pulses want %0d", irq_cnt - c0, tot); end
        reg_read(3'd1, v);
        vectors++;
        if (v !== exp_stat(1)) begin errors++; $display("FAIL ovf_stat: got %h want %h", v, exp_stat(1)); end
        for (int i = 0; i < 4; i++) begin
            reg_read(3'd0, v);
            vectors++;
            if (v !== exp_data()) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", i, v, exp_data()); end
            do_pop();
        end
        reg_write(3'd1, 32'h0200_0000);
        m_ovf = 1'b0; m_ferr = 1'b0;
        reg_read(3'd1, v);
        vectors++;
        if (v !== exp_stat(1)) begin errors++; $display("FAIL ovf_clear: got %h want %h", v, exp_stat(1)); end
        $display("test_overflow: 5 frames sent, %0d queued", tot);
    endtask

    task automatic test_tx_frame();
        logic [31:0] v;
        logic [7:0]  txb;
        logic        wave[11];
        int n, rise;
        txb = 8'hA5;
        wave[0] = 1'b0;
        for (int i = 0; i < 8; i++) wave[i+1] = txb[i];
        wave[9] = 1'b0; wave[10] = 1'b1;
        reg_write(3'd2, {txb, 24'h0});
        n = 0;
        while (dev_tx !== 1'b0 && n < 8) begin @(negedge clk); n++; end
        vectors++;
        if (dev_tx !== 1'b0) begin errors++; $display("FAIL tx_start: line %b want 0", dev_tx); end
        reg_read(3'd1, v);
        vectors++;
        if (v !== exp_stat(0)) begin errors++; $display("FAIL tx_busy_stat: got %h want %h", v, exp_stat(0)); end
        n = 0;
        while (dev_tx !== 1'b1 && n < BIT + 8) begin @(negedge clk); n++; end
        vectors++;
        if (dev_tx !== 1'b1) begin errors++; $display("FAIL tx_bit0_edge: line %b want 1", dev_tx); end
        rise = cyc;
        tx_phase = rise;
        reg_write(3'd2, 32'hFF00_0000);   // must be ignored while busy
        for (int i = 1; i < 11; i++) begin
            while (cyc < rise + BIT / 2 + (i - 1) * BIT) @(negedge clk);
            vectors++;
            if (dev_tx !== wave[i]) begin errors++; $display("FAIL tx_bit%0d: line %b want %b", i, dev_tx, wave[i]); end
        end
        repeat (BIT) @(negedge clk);
        reg_read(3'd1, v);
        vectors++;
        if (v !== exp_stat(1)) begin errors++; $display("FAIL tx_idle_stat: got %h want %h", v, exp_stat(1)); end
        n = 0;
        for (int i = 0; i < 2 * BIT; i++) begin
            @(negedge clk);
            if (dev_tx !== 1'b1) n++;
        end
        vectors++;
        if (n != 0) begin errors++; $display("FAIL tx_second_write: line low %0d cycles want 0", n); end
        $display("test_tx_frame: sent %h", txb);
    endtask

    task automatic test_ferr();
        logic [31:0] v;
        int c0, ei;
        c0 = irq_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, ei);
        vectors++;
        if (irq_cnt - c0 !== 0) begin errors++; $display("FAIL ferr_irq: got %0d pulses want 0", irq_cnt - c0); end
        reg_read(3'd1, v);
        vectors++;
        if (v !== exp_stat(1)) begin errors++; $display("FAIL ferr_stat: got %h want %h", v, exp_stat(1)); end
        c0 = irq_cnt;
        send_frame(8'h7E, 1'b0, 1'b1, ei);
        vectors++;
        if (irq_cnt - c0 !== ei) begin errors++; $display("FAIL ferr_next_irq: got %0d want %0d", irq_cnt - c0, ei); end
        reg_read(3'd0, v);
        vectors++;
        if (v !== exp_data()) begin errors++; $display("FAIL ferr_next_data: got %h want %h", v, exp_data()); end
        $display("test_ferr: bad 3C then 7E, head %h", v);
    endtask

    task automatic test_loopback();
        logic [31:0] v;
        int c0;
        while (mq.size() > 0) do_pop();
        reg_write(3'd1, 32'h0200_0000);
        m_ovf = 1'b0; m_ferr = 1'b0;
        loop_en = 1'b1;
        while (((cyc - tx_phase) % BIT) != 0) @(negedge clk);
        c0 = irq_cnt;
        reg_write(3'd2, 32'h5A00_0000);
        repeat (13 * BIT) @(negedge clk);
        loop_en = 1'b0;
        mq.push_back({1'b0, 8'h5A});
        vectors++;
        if (irq_cnt - c0 !== 1) begin errors++; $display("FAIL loop_irq: got %0d pulses want 1", irq_cnt - c0); end
        reg_read(3'd0, v);
        vectors++;
        if (v !== exp_data()) begin errors++; $display("FAIL loop_data: got %h want %h", v, exp_data()); end
        reg_read(3'd1, v);
        vectors++;
        if (v !== exp_stat(1)) begin errors++; $display("FAIL loop_stat: got %h want %h", v, exp_stat(1)); end
        $display("test_loopback: looped 5A, read %h", v);
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [7:0]  rd;
        logic        rf;
        int c0, ei, op;
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 5 || op == 9) begin
                rd = 8'($urandom);
                rf = 1'($urandom);
                c0 = irq_cnt;
                send_frame(rd, rf, (op != 9), ei);
                vectors++;
                if (irq_cnt - c0 !== ei) begin errors++; $display("FAIL rand%0d_irq: got %0d want %0d", it, irq_cnt - c0, ei); end
                $display("rand%0d: frame %h flag %b stop_ok %b", it, rd, rf, (op != 9));
            end else if (op <= 7) begin
                do_pop();
                $display("rand%0d: pop", it);
            end else begin
                reg_write(3'd1, 32'h0200_0000);
                m_ovf = 1'b0; m_ferr = 1'b0;
                $display("rand%0d: clear", it);
            end
            reg_read(3'd1, v);
            vectors++;
            if (v !== exp_stat(1)) begin errors++; $display("FAIL rand%0d_stat: got %h want %h", it, v, exp_stat(1)); end
            reg_read(3'd0, v);
            vectors++;
            if (v !== exp_data()) begin errors++; $display("FAIL rand%0d_data: got %h want %h", it, v, exp_data()); end
        end
    endtask

    task automatic test_nint_reset();
        logic [31:0] v;
        int ei;
        reg_write(3'd3, 32'h0000_0000);
        vectors++;
        if (dev_nint !== 1'b0) begin errors++; $display("FAIL nint_low: line %b want 0", dev_nint); end
        reg_read(3'd3, v);
        vectors++;
        if (v !== 32'h0) begin errors++; $display("FAIL nint_read: got %h want 0", v); end
        reg_write(3'd3, 32'h0100_0000);
        reg_read(3'd3, v);
        vectors++;
        if (v !== 32'h0100_0000 || dev_nint !== 1'b1) begin
            errors++; $display("FAIL nint_high: read %h line %b want 01000000 1", v, dev_nint);
        end
        reg_write(3'd3, 32'h0000_0000);
        while (mq.size() > 0) do_pop();
        send_frame(8'h42, 1'b1, 1'b1, ei);
        reg_write(3'd2, 32'hA500_0000);
        repeat (3 * BIT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
        vectors++;
        if (dev_tx !== 1'b1 || dev_nint !== 1'b1) begin
            errors++; $display("FAIL rst_lines: tx=%b nint=%b want 1 1", dev_tx, dev_nint);
        end
        bus.a = 3'd1;
        #1;
        vectors++;
        if (bus.spo !== exp_stat(1)) begin errors++; $display("FAIL rst_stat: got %h want %h", bus.spo, exp_stat(1)); end
        @(negedge clk);
        rst = 1'b0;
        $display("test_nint_reset done");
    endtask

    initial begin
        bus.a = '0; bus.d = '0; bus.we = 1'b0;
        test_reset();
        test_cmd_frame();
        test_overflow();
        test_tx_frame();
        test_ferr();
        test_loopback();
        test_random();
        test_nint_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
